// File: rtl/soc_addr_map_rt.sv
// soc_addr_map_rt: runtime-programmable address map with 1-cycle registered lookup and config port.
// Define SOC_ADDR_MAP_HIT_CNT_EN to add per-rule saturating 32-bit hit counters (field 3).
module soc_addr_map_rt #(
   parameter int NumRules = 10,
   parameter int AddrWidth = 64,
   parameter logic [NumRules-1:0][AddrWidth-1:0] RstBase = '0,
   parameter logic [NumRules-1:0][AddrWidth-1:0] RstLength = '0,
   parameter int IdxW = (NumRules > 1) ? $clog2(NumRules) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [IdxW+1:0]      cfg_addr_i,
   input  logic [63:0]          cfg_wdata_i,
   output logic [63:0]          cfg_rdata_o,
   output logic                 cfg_err_o,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [IdxW-1:0]      rsp_idx_o,
   output logic                 rsp_miss_o
);
`ifdef SOC_ADDR_MAP_HIT_CNT_EN
   localparam bit HasCnt = 1'b1;
   logic [31:0] hit_q [NumRules];
   logic [31:0] hit_d [NumRules];
`else
   localparam bit HasCnt = 1'b0;
`endif
   logic [AddrWidth-1:0] base_q [NumRules];
   logic [AddrWidth-1:0] base_d [NumRules];
   logic [AddrWidth-1:0] len_q [NumRules];
   logic [AddrWidth-1:0] len_d [NumRules];
   logic [NumRules-1:0]  en_q, en_d, lock_q, lock_d;
   logic                 rsp_valid_q, rsp_valid_d, rsp_miss_q, rsp_miss_d, cfg_err_q, cfg_err_d;
   logic [IdxW-1:0]      rsp_idx_q, rsp_idx_d, hit_idx, cfg_rule;
   logic [63:0]          cfg_rdata_q, cfg_rdata_d, rd_val;
   logic [1:0]           cfg_fld;
   logic                 hit_any, acc, rule_ok, sel_lock, wr_err, wr_ok;
   assign req_ready_o = !rsp_valid_q || rsp_ready_i;
   assign acc = req_valid_i && req_ready_o;
   assign cfg_rule = cfg_addr_i[IdxW+1:2];
   assign cfg_fld = cfg_addr_i[1:0];
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_idx_o = rsp_idx_q;
   assign rsp_miss_o = rsp_miss_q;
   assign cfg_rdata_o = cfg_rdata_q;
   assign cfg_err_o = cfg_err_q;
   // Compare in AddrWidth+1 bits so base+length past the top of the space does not wrap.
   always_comb begin
      hit_idx = '0;
      hit_any = 1'b0;
      for (int i = NumRules - 1; i >= 0; i--) begin
         if (en_q[i] && len_q[i] != '0 && {1'b0, req_addr_i} >= {1'b0, base_q[i]} &&
             {1'b0, req_addr_i} < {1'b0, base_q[i]} + {1'b0, len_q[i]}) begin
            hit_idx = IdxW'(i);
            hit_any = 1'b1;
         end
      end
   end
   always_comb begin
      rule_ok = 1'b0;
      sel_lock = 1'b0;
      rd_val = '0;
      for (int i = 0; i < NumRules; i++) begin
         if (cfg_rule == IdxW'(i)) begin
            rule_ok = 1'b1;
            sel_lock = lock_q[i];
`ifdef SOC_ADDR_MAP_HIT_CNT_EN
            rd_val = cfg_fld == 2'd0 ? 64'(base_q[i]) : cfg_fld == 2'd1 ? 64'(len_q[i]) :
                     cfg_fld == 2'd2 ? {62'd0, lock_q[i], en_q[i]} : {32'd0, hit_q[i]};
`else
            rd_val = cfg_fld == 2'd0 ? 64'(base_q[i]) : cfg_fld == 2'd1 ? 64'(len_q[i]) :
                     cfg_fld == 2'd2 ? {62'd0, lock_q[i], en_q[i]} : 64'd0;
`endif
         end
      end
      wr_err = !rule_ok || (cfg_fld == 2'd3 ? !HasCnt : sel_lock);
      wr_ok = cfg_req_i && cfg_we_i && !wr_err;
      cfg_err_d = cfg_req_i && (!rule_ok || (cfg_we_i && wr_err));
      cfg_rdata_d = (cfg_req_i && !cfg_we_i && rule_ok) ? rd_val : 64'd0;
   end
   always_comb begin
      for (int i = 0; i < NumRules; i++) begin
         base_d[i] = (wr_ok && cfg_rule == IdxW'(i) && cfg_fld == 2'd0) ? cfg_wdata_i[AddrWidth-1:0] : base_q[i];
         len_d[i] = (wr_ok && cfg_rule == IdxW'(i) && cfg_fld == 2'd1) ? cfg_wdata_i[AddrWidth-1:0] : len_q[i];
         en_d[i] = (wr_ok && cfg_rule == IdxW'(i) && cfg_fld == 2'd2) ? cfg_wdata_i[0] : en_q[i];
         lock_d[i] = (wr_ok && cfg_rule == IdxW'(i) && cfg_fld == 2'd2) ? cfg_wdata_i[1] : lock_q[i];
`ifdef SOC_ADDR_MAP_HIT_CNT_EN
         // A clear write beats a hit landing on the same edge.
         hit_d[i] = (wr_ok && cfg_rule == IdxW'(i) && cfg_fld == 2'd3) ? 32'd0 :
                    (acc && hit_any && hit_idx == IdxW'(i) && hit_q[i] != '1) ? hit_q[i] + 32'd1 : hit_q[i];
`endif
      end
      rsp_valid_d = acc ? 1'b1 : (rsp_ready_i ? 1'b0 : rsp_valid_q);
      rsp_idx_d = acc ? hit_idx : rsp_idx_q;
      rsp_miss_d = acc ? !hit_any : rsp_miss_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumRules; i++) begin
            base_q[i] <= RstBase[i];
            len_q[i] <= RstLength[i];
`ifdef SOC_ADDR_MAP_HIT_CNT_EN
            hit_q[i] <= '0;
`endif
         end
         en_q <= '1;
         lock_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_idx_q <= '0;
         rsp_miss_q <= 1'b0;
         cfg_rdata_q <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NumRules; i++) begin
            base_q[i] <= base_d[i];
            len_q[i] <= len_d[i];
`ifdef SOC_ADDR_MAP_HIT_CNT_EN
            hit_q[i] <= hit_d[i];
`endif
         end
         en_q <= en_d;
         lock_q <= lock_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_idx_q <= rsp_idx_d;
         rsp_miss_q <= rsp_miss_d;
         cfg_rdata_q <= cfg_rdata_d;
         cfg_err_q <= cfg_err_d;
      end
   end
endmodule
